mcs4_bus_fabric: RTL and testbench
==================================

Name: mcs4_bus_fabric

Overview:
Parametrised data-bus interconnect and bus monitor for an MCS-4 system with ROM_CHIPS ROMs and RAM_BANKS x BANK_CHIPS RAM chips.
- Merges all agent dbus_out nibbles into the shared 4-bit bus.
- Tracks the 8-phase instruction cycle from sync.
- Emits one trace record per instruction cycle: 12-bit PC, OPR, OPA.
- Detects multi-driver bus contention and keeps cycle and contention counters.
- Sits at system top, between the i4004, i4001 and i4002 instances.

Parameters:
ROM_CHIPS, 2, number of i4001 dbus_out inputs (1..16)
RAM_BANKS, 4, RAM banks, one cm_ram bit each (1..4)
BANK_CHIPS, 4, i4002 chips per bank (1..4)
CNT_W, 32, width of cycle_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sync  in  1  i4004 sync; high in a cycle means the next cycle is A1
cm_rom  in  1  i4004 ROM command line
cm_ram  in  RAM_BANKS  i4004 RAM bank command lines
d_cpu  in  4  i4004 dbus_out
d_rom  in  ROM_CHIPS x 4  i4001 dbus_out per chip
d_ram  in  RAM_BANKS*BANK_CHIPS x 4  i4002 dbus_out, index bank*BANK_CHIPS+chip
d_bus  out  4  merged bus: OR of all drivers, combinational
phase  out  3  current phase (mcs4::phase_t)
locked  out  1  a sync has been seen since reset
sync_err  out  1  one-cycle pulse: sync arrived at a phase other than X3 while locked
trace_valid  out  1  one-cycle pulse carrying a completed trace record
trace_pc  out  12  {A3,A2,A1} nibbles
trace_opr  out  4  nibble sampled at M1
trace_opa  out  4  nibble sampled at M2
trace_cm_rom  out  1  cm_rom sampled at A3
contention  out  1  one-cycle pulse: more than one driver nonzero in the previous cycle
contention_cnt  out  16  saturating count of contention events
cycle_cnt  out  CNT_W  count of completed instruction cycles, wrapping
dbg_clear  in  1  synchronous clear of contention_cnt and cycle_cnt

Behaviour:
- Reset (async, rst=1): phase=X3, locked=0, all pulses 0, trace_* =0, both counters =0. d_bus stays combinational and is unaffected by reset.
- Phase encoding: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- Phase next-state:
  - sync=1 → A1.
  - Else if phase=X3 → hold X3 (CPU in reset or stalled).
  - Else → phase+1.
  - First sync sets locked=1. locked stays 1 until reset.
- sync_err: asserted the cycle after sync=1 seen with locked=1 and phase≠X3. The phase still resynchronises to A1.
- Capture: only when locked.
  - Register d_bus into pc[3:0] at A1, pc[7:4] at A2, pc[11:8] at A3.
  - Register cm_rom into trace_cm_rom at A3.
  - Register d_bus into opr at M1 and opa at M2.
  - Captures are internal shadows. trace_* outputs update only together with trace_valid.
- Trace emit: on the cycle phase=X1, copy the shadows to trace_* and pulse trace_valid for one cycle; trace_* hold until the next emit. Latency is 1 cycle after the M2 capture.
- Cycle abort: if a resync (sync_err case) occurs before X1, no record is emitted for the aborted cycle.
- cycle_cnt: increments on each trace_valid and wraps at 2^CNT_W.
- Contention: in each locked cycle, count drivers with a nonzero nibble across d_cpu, all d_rom and all d_ram. If the count is >1, pulse contention the next cycle.
  - contention_cnt +1 per pulse, saturating at 16'hFFFF.
  - A zero-valued drive is indistinguishable from idle by design.
- dbg_clear=1: next cycle both counters are 0. If dbg_clear coincides with an increment event, clear wins. Phase and trace are unaffected.
- Unused cm_ram bits: the block exposes only RAM_BANKS bits. The top ties cm_ram[RAM_BANKS-1:0] from the CPU.

Decomposition:
- mcs4 package: phase_t enum (A1..X3), trace_t struct {pc[11:0], opr, opa, cm_rom}, NUM_PHASES=8.
- Sub-module mcs4_phase_tracker: sync → phase, locked, sync_err, a one-hot phase strobe.
- Top block: OR-merge, popcount contention, trace shadows, counters.

Test Plan:
- Reset then idle (sync=0, all drivers 0) → phase=X3, locked=0, no trace_valid, counters 0 for 20 cycles.
- sync pulse, then d_bus sequence A1=4'h3, A2=4'h2, A3=4'h1, M1=4'hD, M2=4'h5 driven by d_cpu/d_rom[1] → trace_valid at X1 with trace_pc=12'h123, opr=4'hD, opa=4'h5; cycle_cnt=1.
- Back-to-back 300 instruction cycles with CNT_W=8 → cycle_cnt wraps to 44, trace_valid every 8 cycles.
- sync asserted at M1 while locked → sync_err pulse, phase=A1 next cycle, no trace_valid for the aborted cycle.
- d_cpu=4'h1 and d_ram[5]=4'h2 in the same cycle → d_bus=4'h3, contention pulse next cycle, contention_cnt=1. Force 70000 events → saturates at 16'hFFFF. dbg_clear → 0.
- Assert rst mid-M1 → all outputs back to reset values immediately. The next sync relocks and the first record is correct.

Source files
------------

// File: rtl/mcs4_pkg.sv
// Shared types for the MCS-4 bus fabric: instruction-cycle phases and the
// per-cycle trace record (PC, OPR, OPA, cm_rom at A3).
package mcs4_pkg;

    localparam int NUM_PHASES = 8;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    typedef struct packed {
        logic [11:0] pc;
        logic [3:0]  opr;
        logic [3:0]  opa;
        logic        cm_rom;
    } trace_t;

endpackage

// File: rtl/mcs4_phase_tracker.sv
// Follows the i4004 sync line to produce the current phase, a lock flag,
// a one-hot phase strobe and a pulse when sync arrives out of place.
// Ports: clk, rst, sync -> phase, locked, sync_err, phase_oh.
module mcs4_phase_tracker
    import mcs4_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync,
    output phase_t                phase,
    output logic                  locked,
    output logic                  sync_err,
    output logic [NUM_PHASES-1:0] phase_oh
);

    phase_t phase_next;

    // X3 holds while the CPU is stalled or in reset; sync always wins.
    always_comb begin
        phase_next = phase;
        if (sync) begin
            phase_next = PH_A1;
        end else if (phase != PH_X3) begin
            phase_next = phase_t'(phase + 3'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= PH_X3;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            phase    <= phase_next;
            sync_err <= sync && locked && (phase != PH_X3);
            if (sync) begin
                locked <= 1'b1;
            end
        end
    end

    assign phase_oh = NUM_PHASES'(1) << phase;

endmodule

// File: rtl/mcs4_bus_fabric.sv
// MCS-4 data-bus OR-merge plus bus monitor: phase tracking, one trace
// record per instruction cycle, contention detection and counters.
// Ports: sync/cm_* and agent nibbles in; d_bus, phase, trace_*,
// contention pulses and counters out; dbg_clear zeroes the counters.
module mcs4_bus_fabric
    import mcs4_pkg::*;
#(
    parameter int ROM_CHIPS  = 2,
    parameter int RAM_BANKS  = 4,
    parameter int BANK_CHIPS = 4,
    parameter int CNT_W      = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sync,
    input  logic                                 cm_rom,
    input  logic [RAM_BANKS-1:0]                 cm_ram,
    input  logic [3:0]                           d_cpu,
    input  logic [ROM_CHIPS-1:0][3:0]            d_rom,
    input  logic [RAM_BANKS*BANK_CHIPS-1:0][3:0] d_ram,
    output logic [3:0]                           d_bus,
    output phase_t                               phase,
    output logic                                 locked,
    output logic                                 sync_err,
    output logic                                 trace_valid,
    output logic [11:0]                          trace_pc,
    output logic [3:0]                           trace_opr,
    output logic [3:0]                           trace_opa,
    output logic                                 trace_cm_rom,
    output logic                                 contention,
    output logic [15:0]                          contention_cnt,
    output logic [CNT_W-1:0]                     cycle_cnt,
    input  logic                                 dbg_clear
);

    logic [NUM_PHASES-1:0] ph_oh;
    logic [5:0]            n_drv;
    logic                  multi;
    logic                  emit;
    logic [11:0]           sh_pc;
    logic [3:0]            sh_opr;
    logic                  sh_cm_rom;
    trace_t                trace_q;

    // cm_ram only selects RAM chips; the monitor has no use for it.
    logic unused_cm_ram;
    assign unused_cm_ram = ^cm_ram;

    mcs4_phase_tracker u_phase (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .phase    (phase),
        .locked   (locked),
        .sync_err (sync_err),
        .phase_oh (ph_oh)
    );

    always_comb begin
        d_bus = d_cpu;
        n_drv = 6'(|d_cpu);
        for (int i = 0; i < ROM_CHIPS; i++) begin
            d_bus = d_bus | d_rom[i];
            n_drv = n_drv + 6'(|d_rom[i]);
        end
        for (int i = 0; i < RAM_BANKS * BANK_CHIPS; i++) begin
            d_bus = d_bus | d_ram[i];
            n_drv = n_drv + 6'(|d_ram[i]);
        end
    end

    assign multi = locked && (n_drv > 6'd1);

    // Record leaves as the cycle enters X1; OPA bypasses its shadow.
    // A resync during M2 suppresses the aborted cycle's record.
    assign emit = locked && ph_oh[PH_M2] && !sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_pc          <= '0;
            sh_opr         <= '0;
            sh_cm_rom      <= 1'b0;
            trace_q        <= '0;
            trace_valid    <= 1'b0;
            contention     <= 1'b0;
            contention_cnt <= '0;
            cycle_cnt      <= '0;
        end else begin
            if (locked) begin
                if (ph_oh[PH_A1]) sh_pc[3:0]  <= d_bus;
                if (ph_oh[PH_A2]) sh_pc[7:4]  <= d_bus;
                if (ph_oh[PH_A3]) sh_pc[11:8] <= d_bus;
                if (ph_oh[PH_A3]) sh_cm_rom   <= cm_rom;
                if (ph_oh[PH_M1]) sh_opr      <= d_bus;
            end
            trace_valid <= emit;
            if (emit) begin
                trace_q <= '{pc: sh_pc, opr: sh_opr,
                             opa: d_bus, cm_rom: sh_cm_rom};
            end
            contention <= multi;
            if (dbg_clear) begin
                contention_cnt <= '0;
                cycle_cnt      <= '0;
            end else begin
                if (emit) begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                end
                if (multi && (contention_cnt != 16'hFFFF)) begin
                    contention_cnt <= contention_cnt + 16'd1;
                end
            end
        end
    end

    assign trace_pc     = trace_q.pc;
    assign trace_opr    = trace_q.opr;
    assign trace_opa    = trace_q.opa;
    assign trace_cm_rom = trace_q.cm_rom;

endmodule

// File: tb/tb_mcs4_bus_fabric.sv
// Directed bench for mcs4_bus_fabric (CNT_W=8 to exercise wrap).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_mcs4_bus_fabric;
    import mcs4_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             sync;
    logic             cm_rom;
    logic [3:0]       cm_ram;
    logic [3:0]       d_cpu;
    logic [1:0][3:0]  d_rom;
    logic [15:0][3:0] d_ram;
    logic [3:0]       d_bus;
    phase_t           phase;
    logic             locked;
    logic             sync_err;
    logic             trace_valid;
    logic [11:0]      trace_pc;
    logic [3:0]       trace_opr;
    logic [3:0]       trace_opa;
    logic             trace_cm_rom;
    logic             contention;
    logic [15:0]      contention_cnt;
    logic [7:0]       cycle_cnt;
    logic             dbg_clear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcs4_bus_fabric #(
        .ROM_CHIPS  (2),
        .RAM_BANKS  (4),
        .BANK_CHIPS (4),
        .CNT_W      (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sync           (sync),
        .cm_rom         (cm_rom),
        .cm_ram         (cm_ram),
        .d_cpu          (d_cpu),
        .d_rom          (d_rom),
        .d_ram          (d_ram),
        .d_bus          (d_bus),
        .phase          (phase),
        .locked         (locked),
        .sync_err       (sync_err),
        .trace_valid    (trace_valid),
        .trace_pc       (trace_pc),
        .trace_opr      (trace_opr),
        .trace_opa      (trace_opa),
        .trace_cm_rom   (trace_cm_rom),
        .contention     (contention),
        .contention_cnt (contention_cnt),
        .cycle_cnt      (cycle_cnt),
        .dbg_clear      (dbg_clear)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the phase at A1; returns with the phase at X3.
    task automatic body(input logic [11:0] pc, input logic [3:0] opr,
                        input logic [3:0] opa, input logic cmr);
        d_cpu = pc[3:0];
        tick();
        d_cpu = pc[7:4];
        tick();
        d_cpu  = pc[11:8];
        cm_rom = cmr;
        tick();
        d_cpu    = 4'h0;
        cm_rom   = 1'b0;
        d_rom[1] = opr;
        tick();
        d_rom[1] = opa;
        tick();
        d_rom[1] = 4'h0;
        chk("x1_phase", 32'(phase), 32'(PH_X1));
        chk("x1_valid", 32'(trace_valid), 32'd1);
        chk("x1_pc", 32'(trace_pc), 32'(pc));
        chk("x1_opr", 32'(trace_opr), 32'(opr));
        chk("x1_opa", 32'(trace_opa), 32'(opa));
        chk("x1_cm_rom", 32'(trace_cm_rom), 32'(cmr));
        tick();
        chk("x2_valid", 32'(trace_valid), 32'd0);
        tick();
    endtask

    task automatic run_cycle(input logic [11:0] pc, input logic [3:0] opr,
                             input logic [3:0] opa, input logic cmr);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("a1_phase", 32'(phase), 32'(PH_A1));
        chk("a1_no_err", 32'(sync_err), 32'd0);
        body(pc, opr, opa, cmr);
    endtask

    initial begin
        rst       = 1'b1;
        sync      = 1'b0;
        cm_rom    = 1'b0;
        cm_ram    = 4'h0;
        d_cpu     = 4'h0;
        d_rom     = '0;
        d_ram     = '0;
        dbg_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_phase", 32'(phase), 32'(PH_X3));
            chk("idle_locked", 32'(locked), 32'd0);
            chk("idle_valid", 32'(trace_valid), 32'd0);
            chk("idle_cycle_cnt", 32'(cycle_cnt), 32'd0);
            chk("idle_cont_cnt", 32'(contention_cnt), 32'd0);
        end

        // first record
        run_cycle(12'h123, 4'hD, 4'h5, 1'b1);
        chk("rec1_locked", 32'(locked), 32'd1);
        chk("rec1_cycle_cnt", 32'(cycle_cnt), 32'd1);
        chk("rec1_hold_pc", 32'(trace_pc), 32'h123);
        chk("rec1_x3_phase", 32'(phase), 32'(PH_X3));
        chk("rec1_no_cont", 32'(contention_cnt), 32'd0);

        // 300 back-to-back cycles wrap an 8-bit counter to 44
        dbg_clear = 1'b1;
        tick();
        dbg_clear = 1'b0;
        chk("clr_cycle_cnt", 32'(cycle_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            run_cycle(12'(i * 37 + 5), 4'(i), 4'(i * 3), i[0]);
        end
        chk("wrap_cycle_cnt", 32'(cycle_cnt), 32'd44);

        // resync at M1 aborts the cycle in flight
        sync = 1'b1;
        tick();
        sync  = 1'b0;
        d_cpu = 4'hE;
        tick();
        tick();
        tick();
        d_cpu = 4'h0;
        chk("pre_abort_phase", 32'(phase), 32'(PH_M1));
        sync     = 1'b1;
        d_rom[1] = 4'h9;
        tick();
        sync     = 1'b0;
        d_rom[1] = 4'h0;
        chk("abort_sync_err", 32'(sync_err), 32'd1);
        chk("abort_phase", 32'(phase), 32'(PH_A1));
        chk("abort_no_valid", 32'(trace_valid), 32'd0);
        chk("abort_cycle_cnt", 32'(cycle_cnt), 32'd44);
        body(12'h7A2, 4'h4, 4'hB, 1'b0);
        chk("post_abort_cnt", 32'(cycle_cnt), 32'd45);
        chk("post_abort_err", 32'(sync_err), 32'd0);

        // contention: two nonzero drivers
        d_cpu    = 4'h1;
        d_ram[5] = 4'h2;
        #1;
        chk("or_merge", 32'(d_bus), 32'h3);
        tick();
        chk("cont_pulse", 32'(contention), 32'd1);
        chk("cont_cnt1", 32'(contention_cnt), 32'd1);
        d_cpu    = 4'h0;
        d_ram[5] = 4'h0;
        d_rom[0] = 4'hF;
        tick();
        chk("cont_pulse_end", 32'(contention), 32'd0);
        tick();
        chk("single_no_cont", 32'(contention), 32'd0);
        chk("single_cnt", 32'(contention_cnt), 32'd1);
        d_ram[15] = 4'h8;
        repeat (70000) tick();
        chk("sat_pulse", 32'(contention), 32'd1);
        chk("sat_cnt", 32'(contention_cnt), 32'hFFFF);
        dbg_clear = 1'b1;
        tick();
        dbg_clear = 1'b0;
        d_rom[0]  = 4'h0;
        d_ram[15] = 4'h0;
        chk("clr_wins_cont", 32'(contention_cnt), 32'd0);
        chk("clr_wins_cycle", 32'(cycle_cnt), 32'd0);
        tick();
        chk("clr_cont_stays", 32'(contention_cnt), 32'd0);
        chk("clr_phase_kept", 32'(phase), 32'(PH_X3));

        // async reset in the middle of M1
        run_cycle(12'h5A6, 4'h2, 4'h3, 1'b1);
        chk("pre_rst_cnt", 32'(cycle_cnt), 32'd1);
        sync = 1'b1;
        tick();
        sync  = 1'b0;
        d_cpu = 4'hC;
        tick();
        tick();
        tick();
        d_cpu = 4'h0;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_phase", 32'(phase), 32'(PH_X3));
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_pc", 32'(trace_pc), 32'd0);
        chk("rst_cm_rom", 32'(trace_cm_rom), 32'd0);
        chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("rst_cont_cnt", 32'(contention_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_idle_phase", 32'(phase), 32'(PH_X3));
        run_cycle(12'hABC, 4'h1, 4'hF, 1'b0);
        chk("relock_cnt", 32'(cycle_cnt), 32'd1);
        chk("relock_locked", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
